// File: rtl/micro_tile_switch_ctrl_if.sv
// Request/status bundle between the tile-select controller and its requester.
// The slave side is the controller; the master side issues switch requests.
interface micro_tile_switch_ctrl_if #(
  parameter int NUM_TILES = 4,
  parameter int SEL_W     = 2
);
  logic                 req_valid;
  logic [SEL_W-1:0]     req_sel;
  logic                 req_ready;
  logic [SEL_W-1:0]     active_sel;
  logic [NUM_TILES-1:0] tile_clk_en;
  logic [NUM_TILES-1:0] tile_rst_n;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output req_valid, req_sel,
    input  req_ready, active_sel, tile_clk_en, tile_rst_n, busy, done, err
  );

  modport slave (
    input  req_valid, req_sel,
    output req_ready, active_sel, tile_clk_en, tile_rst_n, busy, done, err
  );
endinterface

// File: rtl/micro_tile_switch_ctrl.sv
// Tile select sequencer: owns the active tile index, per-tile clock enables and resets,
// and walks quiesce -> gate -> switch -> wake so the select never moves under a running clock.
module micro_tile_switch_ctrl #(
  parameter int NUM_TILES = 4,
  parameter int SEL_W     = 2,
  parameter int RST_HOLD  = 4,
  parameter int GUARD     = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  micro_tile_switch_ctrl_if.slave        io_sw
);
  localparam int CNT_MAX = (RST_HOLD > GUARD) ? RST_HOLD : GUARD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {S_IDLE, S_QUIESCE, S_GATE, S_SWITCH, S_WAKE} state_t;

  state_t               r_state, w_state_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic [SEL_W-1:0]     r_target;
  logic [SEL_W-1:0]     r_active_sel, w_active_sel_next;
  logic [NUM_TILES-1:0] r_clk_en, w_clk_en_next;
  logic [NUM_TILES-1:0] r_tile_rst_n, w_tile_rst_n_next;
  logic [NUM_TILES-1:0] w_oh_cur, w_oh_next;
  logic                 r_req_ready, w_req_ready_next;
  logic                 r_busy, w_busy_next;
  logic                 r_done, w_done_next;
  logic                 r_err, w_err_next;
  logic                 w_accept, w_sel_illegal, w_sel_same;

  assign w_accept      = io_sw.req_valid & r_req_ready;
  assign w_sel_illegal = 32'(io_sw.req_sel) >= NUM_TILES;
  assign w_sel_same    = (io_sw.req_sel == r_active_sel);

  // The select only ever moves on the SWITCH -> WAKE edge, while every clock is gated.
  assign w_active_sel_next = (r_state == S_SWITCH) ? r_target : r_active_sel;

  for (genvar gi = 0; gi < NUM_TILES; gi++) begin : g_onehot
    assign w_oh_cur[gi]  = (r_active_sel == SEL_W'(gi));
    assign w_oh_next[gi] = (w_active_sel_next == SEL_W'(gi));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_WAKE;
      r_cnt    <= '0;
      r_target <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept && !w_sel_illegal) begin
        r_target <= io_sw.req_sel;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_sel_illegal) begin
          w_state_next = w_sel_same ? S_WAKE : S_QUIESCE;
        end
      end
      S_QUIESCE: if (r_cnt == CNT_W'(RST_HOLD - 1)) w_state_next = S_GATE;
      S_GATE:    if (r_cnt == CNT_W'(GUARD - 1))    w_state_next = S_SWITCH;
      S_SWITCH:  w_state_next = S_WAKE;
      S_WAKE:    if (r_cnt == CNT_W'(RST_HOLD - 1)) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
    // Duration counter restarts on every state entry and stays parked in IDLE.
    w_cnt_next = ((w_state_next != r_state) || (r_state == S_IDLE)) ? '0 : r_cnt + 1'b1;
  end

  always_comb begin
    w_clk_en_next     = '0;
    w_tile_rst_n_next = '0;
    case (w_state_next)
      S_IDLE: begin
        w_clk_en_next     = w_oh_next;
        w_tile_rst_n_next = w_oh_next;
      end
      S_QUIESCE: w_clk_en_next = w_oh_cur;
      S_WAKE:    w_clk_en_next = w_oh_next;
      default:   w_clk_en_next = '0;
    endcase
    w_req_ready_next = (w_state_next == S_IDLE);
    w_busy_next      = (w_state_next != S_IDLE);
    w_done_next      = (r_state == S_WAKE) && (w_state_next == S_IDLE);
    w_err_next       = (r_state == S_IDLE) && w_accept && w_sel_illegal;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active_sel <= '0;
      r_clk_en     <= NUM_TILES'(1);
      r_tile_rst_n <= '0;
      r_req_ready  <= 1'b0;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_active_sel <= w_active_sel_next;
      r_clk_en     <= w_clk_en_next;
      r_tile_rst_n <= w_tile_rst_n_next;
      r_req_ready  <= w_req_ready_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
      r_err        <= w_err_next;
    end
  end

  assign io_sw.active_sel  = r_active_sel;
  assign io_sw.tile_clk_en = r_clk_en;
  assign io_sw.tile_rst_n  = r_tile_rst_n;
  assign io_sw.req_ready   = r_req_ready;
  assign io_sw.busy        = r_busy;
  assign io_sw.done        = r_done;
  assign io_sw.err         = r_err;
endmodule

// File: tb/tb_micro_tile_switch_ctrl.sv
// Bench for micro_tile_switch_ctrl: directed vector table, hand-written corner sequences,
// and random requests checked against a phase-list reference model.
module tb_micro_tile_switch_ctrl;
  localparam int NT = 4;
  localparam int SW = 2;
  localparam int RH = 4;
  localparam int GD = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  micro_tile_switch_ctrl_if #(.NUM_TILES(NT), .SEL_W(SW)) sw4 ();
  micro_tile_switch_ctrl_if #(.NUM_TILES(3),  .SEL_W(SW)) sw3 ();

  micro_tile_switch_ctrl #(.NUM_TILES(NT), .SEL_W(SW), .RST_HOLD(RH), .GUARD(GD)) dut4 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_sw   (sw4.slave)
  );

  micro_tile_switch_ctrl #(.NUM_TILES(3), .SEL_W(SW), .RST_HOLD(RH), .GUARD(GD)) dut3 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_sw   (sw3.slave)
  );

  // {active_sel, tile_clk_en, tile_rst_n, req_ready, busy, done, err}
  typedef struct packed {
    logic [1:0] asel;
    logic [3:0] clk_en;
    logic [3:0] rst;
    logic       rdy;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  typedef struct {
    logic       v;
    logic [1:0] sel;
    exp_t       e;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  function automatic exp_t busy_e(int a, logic [3:0] c);
    exp_t e;
    e.asel = 2'(a); e.clk_en = c; e.rst = 4'b0000;
    e.rdy = 1'b0; e.busy = 1'b1; e.done = 1'b0; e.err = 1'b0;
    return e;
  endfunction

  function automatic exp_t idle_e(int a, logic d);
    exp_t e;
    e.asel = 2'(a); e.clk_en = 4'(1 << a); e.rst = 4'(1 << a);
    e.rdy = 1'b1; e.busy = 1'b0; e.done = d; e.err = 1'b0;
    return e;
  endfunction

  function automatic exp_t act4();
    return {sw4.active_sel, sw4.tile_clk_en, sw4.tile_rst_n,
            sw4.req_ready, sw4.busy, sw4.done, sw4.err};
  endfunction

  function automatic logic [11:0] act3();
    return {sw3.active_sel, sw3.tile_clk_en, sw3.tile_rst_n,
            sw3.req_ready, sw3.busy, sw3.done, sw3.err};
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (sel,clk_en,rst_n,rdy,busy,done,err) t=%0t",
               nm, got[13:0], want[13:0], $time);
    end
  endtask

  // Invariants watched on every sampled cycle of the 4-tile instance.
  logic [1:0] m_prev_sel;
  logic [3:0] m_prev_en;
  bit         m_prev_ok = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if ($countones(sw4.tile_clk_en) > 1 || (sw4.done && sw4.err)) begin
        n_errors++;
        $display("FAIL invariant: clk_en=%b done=%b err=%b t=%0t",
                 sw4.tile_clk_en, sw4.done, sw4.err, $time);
      end
      if (m_prev_ok && sw4.active_sel != m_prev_sel) begin
        n_checks++;
        if (m_prev_en != 4'b0000) begin
          n_errors++;
          $display("FAIL sel_change_gated: clk_en before change=%b required 0000 t=%0t",
                   m_prev_en, $time);
        end
      end
      m_prev_sel = sw4.active_sel;
      m_prev_en  = sw4.tile_clk_en;
      m_prev_ok  = 1'b1;
    end else begin
      m_prev_ok = 1'b0;
    end
  end

  vec_t tbl[$];

  task automatic add(int n, logic v, logic [1:0] s, exp_t e);
    vec_t r;
    r.v = v; r.sel = s; r.e = e;
    repeat (n) tbl.push_back(r);
  endtask

  initial begin
    exp_t rst_e;
    exp_t mq[$];
    exp_t cur;
    int   m_act;
    int   s;
    logic v;

    rst_e = busy_e(0, 4'b0001);
    sw4.req_valid = 1'b0; sw4.req_sel = 2'd0;
    sw3.req_valid = 1'b0; sw3.req_sel = 2'd0;

    // Reset release wake, 0->2 switch, 2->2 restart with an ignored pulse,
    // 2->0 switch with pulses while busy.
    add(3, 1'b0, 2'd0, busy_e(0, 4'b0001));
    add(1, 1'b1, 2'd2, idle_e(0, 1'b1));
    add(4, 1'b0, 2'd0, busy_e(0, 4'b0001));
    add(3, 1'b0, 2'd0, busy_e(0, 4'b0000));
    add(4, 1'b0, 2'd0, busy_e(2, 4'b0100));
    add(1, 1'b1, 2'd2, idle_e(2, 1'b1));
    add(1, 1'b0, 2'd0, busy_e(2, 4'b0100));
    add(1, 1'b1, 2'd1, busy_e(2, 4'b0100));
    add(2, 1'b0, 2'd0, busy_e(2, 4'b0100));
    add(1, 1'b0, 2'd0, idle_e(2, 1'b1));
    add(1, 1'b1, 2'd0, idle_e(2, 1'b0));
    add(1, 1'b0, 2'd0, busy_e(2, 4'b0100));
    add(1, 1'b1, 2'd1, busy_e(2, 4'b0100));
    add(2, 1'b0, 2'd0, busy_e(2, 4'b0100));
    add(2, 1'b0, 2'd0, busy_e(2, 4'b0000));
    add(1, 1'b1, 2'd1, busy_e(2, 4'b0000));
    add(4, 1'b0, 2'd0, busy_e(0, 4'b0001));
    add(1, 1'b0, 2'd0, idle_e(0, 1'b1));
    add(1, 1'b0, 2'd0, idle_e(0, 1'b0));

    repeat (2) @(negedge clk);
    chk("reset_state", 32'(act4()), 32'(rst_e));
    chk("reset_state3", 32'(act3()), 32'({2'd0, 3'b001, 3'b000, 4'b0100}));
    #2 rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(act4()), 32'(tbl[i].e));
      sw4.req_valid = tbl[i].v;
      sw4.req_sel   = tbl[i].sel;
    end

    // Out-of-range index on a 3-tile instance: err pulse, nothing else moves.
    @(negedge clk);
    sw3.req_valid = 1'b1; sw3.req_sel = 2'd3;
    @(negedge clk);
    sw3.req_valid = 1'b0; sw3.req_sel = 2'd0;
    chk("err_pulse", 32'(act3()), 32'({2'd0, 3'b001, 3'b001, 4'b1001}));
    @(negedge clk);
    chk("err_clear", 32'(act3()), 32'({2'd0, 3'b001, 3'b001, 4'b1000}));

    // 0->3 switch interrupted by reset during GATE.
    chk("pre_rst_idle", 32'(act4()), 32'(idle_e(0, 1'b0)));
    sw4.req_valid = 1'b1; sw4.req_sel = 2'd3;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      sw4.req_valid = 1'b0;
      chk($sformatf("to3_c%0d", k), 32'(act4()),
          32'((k <= RH) ? busy_e(0, 4'b0001) : busy_e(0, 4'b0000)));
    end
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 32'(act4()), 32'(rst_e));
    repeat (2) begin
      @(negedge clk);
      chk("reset_hold", 32'(act4()), 32'(rst_e));
    end
    #2 rst_n = 1'b1;
    for (int k = 1; k <= RH; k++) begin
      @(negedge clk);
      chk($sformatf("rewake_c%0d", k), 32'(act4()),
          32'((k < RH) ? busy_e(0, 4'b0001) : idle_e(0, 1'b1)));
    end
    @(negedge clk);
    chk("rewake_idle", 32'(act4()), 32'(idle_e(0, 1'b0)));

    // Random requests against a phase-list model of the sequence.
    m_act = 0;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if (mq.size() > 0) cur = mq.pop_front();
      else               cur = idle_e(m_act, 1'b0);
      chk("rand", 32'(act4()), 32'(cur));
      v = ($urandom_range(0, 2) == 0);
      s = int'($urandom_range(0, NT - 1));
      sw4.req_valid = v;
      sw4.req_sel   = 2'(s);
      if (v && cur.rdy) begin
        if (s != m_act) begin
          repeat (RH)     mq.push_back(busy_e(m_act, 4'(1 << m_act)));
          repeat (GD + 1) mq.push_back(busy_e(m_act, 4'b0000));
          m_act = s;
        end
        repeat (RH) mq.push_back(busy_e(m_act, 4'(1 << m_act)));
        mq.push_back(idle_e(m_act, 1'b1));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
